mio_bus_ctrl: RTL and testbench

Memory/IO bus controller between the multi-cycle CPU control unit and the on-chip RAM, GPIO and polled input device. It decodes each CPU bus request (MemRead/MemWrite with CPU_MIO) by address and runs the matching access with RAM wait states. It returns read data and a one-cycle `mio_ready` pulse, which the controller's IF, MEM_RD and MEM_WD states wait on.

---
 rtl/mio_bus_ctrl_if.sv | 24 ++
 rtl/mio_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side memory/IO bus between the multi-cycle control unit and mio_bus_ctrl.
//   mem_r / mem_w / cpu_mio : request strobes (MemRead, MemWrite, CPU_MIO)
//   addr / wdata            : byte address and write data
//   rdata / mio_ready       : registered read data and one-cycle completion pulse
// Modports: master = CPU control unit, slave = bus controller.
interface mio_bus_ctrl_if;
    logic        mem_r;
    logic        mem_w;
    logic        cpu_mio;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;

    modport master (
        output mem_r, mem_w, cpu_mio, addr, wdata,
        input  rdata, mio_ready
    );

    modport slave (
        input  mem_r, mem_w, cpu_mio, addr, wdata,
        output rdata, mio_ready
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU bus requests by addr[31:28] and runs
// RAM (with RAM_WAIT wait states), GPIO and polled-device accesses, returning
// registered read data with a one-cycle mio_ready pulse.
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   bus (slave)     : CPU request/response (mio_bus_ctrl_if)
//   ram_*           : synchronous RAM port (word address, write data/strobe, read data)
//   gpio_out/in     : GPIO output register and input pins
//   dev_valid/data  : polled input device status and data byte; dev_ack pops it
//   bus_err         : sticky unmapped-access flag
// Optional feature macro: MIO_BUSERR_EN (unmapped reads return 0xDEADBEEF and
// set bus_err); when undefined unmapped reads return 0 and bus_err stays 0.
module mio_bus_ctrl #(
    parameter int unsigned RAM_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mio_bus_ctrl_if.slave        bus,
    output logic [9:0]           ram_addr,
    output logic [31:0]          ram_wdata,
    output logic                 ram_we,
    input  logic [31:0]          ram_rdata,
    output logic [31:0]          gpio_out,
    input  logic [31:0]          gpio_in,
    input  logic                 dev_valid,
    input  logic [7:0]           dev_data,
    output logic                 dev_ack,
    output logic                 bus_err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [3:0]  REGION_RAM  = 4'h0;
    localparam logic [3:0]  REGION_GPIO = 4'hE;
    localparam logic [3:0]  REGION_DEV  = 4'hF;

`ifdef MIO_BUSERR_EN
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wr_pend;

    logic             req_valid;
    logic             req_write;
    logic [3:0]       region;
    logic             unused_addr_bits;

    // Both strobes set means write.
    assign req_valid = bus.cpu_mio & (bus.mem_r | bus.mem_w);
    assign req_write = bus.mem_w;
    assign region    = bus.addr[31:28];

    // Address bits not used by any decoded target.
    assign unused_addr_bits = ^{bus.addr[27:12], bus.addr[1:0]};

    // Access sequencer; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            wr_pend       <= 1'b0;
            bus.rdata     <= '0;
            bus.mio_ready <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_we        <= 1'b0;
            gpio_out      <= '0;
            dev_ack       <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            // Strobes and the completion pulse last one cycle by default.
            ram_we        <= 1'b0;
            dev_ack       <= 1'b0;
            bus.mio_ready <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (region == REGION_RAM) begin
                            ram_addr  <= bus.addr[11:2];
                            ram_wdata <= bus.wdata;
                            ram_we    <= req_write;
                            wr_pend   <= req_write;
                            wait_cnt  <= CNT_W'(RAM_WAIT);
                            state     <= S_WAIT;
                        end else begin
                            bus.mio_ready <= 1'b1;
                            state         <= S_RESP;
                            case (region)
                                REGION_GPIO: begin
                                    if (req_write) begin
                                        gpio_out <= bus.wdata;
                                    end else begin
                                        bus.rdata <= gpio_in;
                                    end
                                end
                                REGION_DEV: begin
                                    // Writes to STATUS/DATA complete but change nothing.
                                    if (!req_write) begin
                                        if (!bus.addr[2]) begin
                                            bus.rdata <= {31'b0, dev_valid};
                                        end else begin
                                            bus.rdata <= {24'b0, dev_data};
                                            dev_ack   <= 1'b1;
                                        end
                                    end
                                end
                                default: begin
                                    if (!req_write) begin
                                        bus.rdata <= UNMAPPED_RDATA;
                                    end
`ifdef MIO_BUSERR_EN
                                    bus_err <= 1'b1;
`endif
                                end
                            endcase
                        end
                    end
                end

                // Request inputs are not looked at while waiting on the RAM.
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        bus.mio_ready <= 1'b1;
                        state         <= S_RESP;
                        if (!wr_pend) begin
                            bus.rdata <= ram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                // A request still held here is ignored; IDLE re-samples it next cycle.
                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed self-checking bench for mio_bus_ctrl with a behavioural synchronous RAM.
module tb_mio_bus_ctrl;

    localparam int unsigned RAM_WAIT = 2;
    localparam int          MAX_LAT  = 40;

`ifdef MIO_BUSERR_EN
    localparam logic [31:0] EXP_UNMAPPED = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_BUSERR   = 32'd1;
`else
    localparam logic [31:0] EXP_UNMAPPED = 32'h0000_0000;
    localparam logic [31:0] EXP_BUSERR   = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in;
    logic        dev_valid;
    logic [7:0]  dev_data;
    logic        dev_ack;
    logic        bus_err;

    logic [31:0] ram_mem [1024];

    int errors = 0;
    int checks = 0;

    mio_bus_ctrl_if bus ();

    mio_bus_ctrl #(.RAM_WAIT(RAM_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .gpio_out  (gpio_out),
        .gpio_in   (gpio_in),
        .dev_valid (dev_valid),
        .dev_data  (dev_data),
        .dev_ack   (dev_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, write on ram_we.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"},     bus.rdata,           32'd0);
        check({tag, "_mio_ready"}, 32'(bus.mio_ready),  32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),       32'd0);
        check({tag, "_ram_wdata"}, ram_wdata,           32'd0);
        check({tag, "_ram_we"},    32'(ram_we),         32'd0);
        check({tag, "_gpio_out"},  gpio_out,            32'd0);
        check({tag, "_dev_ack"},   32'(dev_ack),        32'd0);
        check({tag, "_bus_err"},   32'(bus_err),        32'd0);
    endtask

    // One access: E0 is the first edge after the request is driven. lat counts
    // samples after E0 until mio_ready is seen (1 = cycle right after E0).
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int we_n, output int ack_n,
                          output logic ack_at_ready, output logic [31:0] rd);
        bus.cpu_mio = 1'b1;
        bus.mem_w   = wr;
        bus.mem_r   = !wr;
        bus.addr    = a;
        bus.wdata   = d;
        lat = 0; we_n = 0; ack_n = 0; ack_at_ready = 1'b0; rd = '0;
        do begin
            step();
            lat++;
            if (ram_we)  we_n++;
            if (dev_ack) ack_n++;
            if (lat == 1) begin
                bus.cpu_mio = 1'b0;
                bus.mem_r   = 1'b0;
                bus.mem_w   = 1'b0;
            end
        end while (!bus.mio_ready && lat < MAX_LAT);
        ack_at_ready = dev_ack;
        rd = bus.rdata;
        step();
        if (ram_we)  we_n++;
        if (dev_ack) ack_n++;
        check("ready_one_cycle", 32'(bus.mio_ready), 32'd0);
    endtask

    initial begin
        int          lat, we_n, ack_n;
        logic        ack_r;
        logic [31:0] rd;
        logic [3:0]  pat;
        logic        seen;

        reset       = 1'b1;
        bus.mem_r   = 1'b0;
        bus.mem_w   = 1'b0;
        bus.cpu_mio = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        gpio_in     = '0;
        dev_valid   = 1'b0;
        dev_data    = '0;

        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // RAM write word 3
        access(1'b1, 32'h0000_000C, 32'h1234_5678, lat, we_n, ack_n, ack_r, rd);
        check("ram_wr_lat",      32'(lat),    32'd3);
        check("ram_wr_we_count", 32'(we_n),   32'd1);
        check("ram_wr_addr",     32'(ram_addr), 32'd3);
        check("ram_wr_wdata",    ram_wdata,   32'h1234_5678);

        // RAM read back
        access(1'b0, 32'h0000_000C, 32'h0, lat, we_n, ack_n, ack_r, rd);
        check("ram_rd_lat",      32'(lat),  32'd3);
        check("ram_rd_data",     rd,        32'h1234_5678);
        check("ram_rd_we_count", 32'(we_n), 32'd0);

        // GPIO write; rdata must keep the previous read value
        access(1'b1, 32'hE000_0000, 32'h0000_00A5, lat, we_n, ack_n, ack_r, rd);
        check("gpio_wr_lat",   32'(lat), 32'd1);
        check("gpio_out",      gpio_out, 32'h0000_00A5);
        check("gpio_wr_rdata", rd,       32'h1234_5678);

        // GPIO read
        gpio_in = 32'hFFFF_0001;
        access(1'b0, 32'hE000_0000, 32'h0, lat, we_n, ack_n, ack_r, rd);
        check("gpio_rd_lat",  32'(lat), 32'd1);
        check("gpio_rd_data", rd,       32'hFFFF_0001);

        // Polled device STATUS then DATA
        dev_valid = 1'b1;
        dev_data  = 8'h3C;
        access(1'b0, 32'hF000_0000, 32'h0, lat, we_n, ack_n, ack_r, rd);
        check("status_data",    rd,         32'd1);
        check("status_no_ack",  32'(ack_n), 32'd0);
        access(1'b0, 32'hF000_0004, 32'h0, lat, we_n, ack_n, ack_r, rd);
        check("dev_data",        rd,          32'h0000_003C);
        check("dev_ack_count",   32'(ack_n),  32'd1);
        check("dev_ack_w_ready", 32'(ack_r),  32'd1);

        // Request held through RESP and the following IDLE cycle
        bus.cpu_mio = 1'b1;
        bus.mem_r   = 1'b1;
        bus.addr    = 32'hE000_0000;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            pat = {pat[2:0], bus.mio_ready};
        end
        bus.cpu_mio = 1'b0;
        bus.mem_r   = 1'b0;
        check("held_req_pattern", 32'(pat), 32'hA);
        step();
        step();

        // Reset during the second WAIT cycle of a RAM read
        bus.cpu_mio = 1'b1;
        bus.mem_r   = 1'b1;
        bus.addr    = 32'h0000_000C;
        step();
        bus.cpu_mio = 1'b0;
        bus.mem_r   = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_all_zero("midwait_reset");
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | bus.mio_ready;
        end
        check("no_ready_after_abort", 32'(seen), 32'd0);
        access(1'b0, 32'h0000_000C, 32'h0, lat, we_n, ack_n, ack_r, rd);
        check("post_reset_rd_lat",  32'(lat), 32'd3);
        check("post_reset_rd_data", rd,       32'h1234_5678);

        // Unmapped read, then a good access; bus_err must hold its value
        access(1'b0, 32'h5000_0000, 32'h0, lat, we_n, ack_n, ack_r, rd);
        check("unmapped_lat",   32'(lat),     32'd1);
        check("unmapped_rdata", rd,           EXP_UNMAPPED);
        check("unmapped_err",   32'(bus_err), EXP_BUSERR);
        access(1'b0, 32'hE000_0000, 32'h0, lat, we_n, ack_n, ack_r, rd);
        check("err_sticky",     32'(bus_err), EXP_BUSERR);
        check("gpio_rd_again",  rd,           32'hFFFF_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
